// File: rtl/artemis_bringup_seq.sv
// Artemis reset/bring-up sequencer: merges board resets, sequences PLL and DDR3 bring-up,
// staggers DDR3 user-port release, retries on timeout and recovers from run-time loss.
module artemis_bringup_seq #(
  parameter int unsigned NUM_RST_SRC        = 2,
  parameter int unsigned NUM_PORTS          = 6,
  parameter int unsigned PLL_RST_CYCLES     = 8,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DDR_RST_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 1048576,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RST_SRC-1:0]           rst_src_n,
  input  logic                             pll_locked,
  input  logic                             calibration_done,
  output logic                             pll_rst,
  output logic                             ddr3_rst,
  output logic [NUM_PORTS-1:0]             port_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             error,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [2:0]                       state
);

  localparam int unsigned MAX_A    = (PLL_RST_CYCLES > DDR_RST_CYCLES) ? PLL_RST_CYCLES : DDR_RST_CYCLES;
  localparam int unsigned MAX_B    = (TIMEOUT_CYCLES > STAGGER_CYCLES) ? TIMEOUT_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_LOAD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_LOAD + 1);
  localparam int unsigned LOCK_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned RETRY_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   PLL_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DDR_LOAD     = CNT_W'(DDR_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST    = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   PORT_LAST    = IDX_W'(NUM_PORTS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DDR_RST   = 3'd2,
    S_WAIT_CAL  = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  logic [NUM_RST_SRC-1:0] src_s1_q, src_s2_q;
  logic                   lock_s1_q, lock_s2_q;
  logic                   cal_s1_q, cal_s2_q;
  logic                   src_ok, lock_ok, cal_ok;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                pll_rst_q, pll_rst_d;
  logic                ddr3_rst_q, ddr3_rst_d;
  logic [NUM_PORTS-1:0] port_rst_q, port_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [NUM_PORTS-1:0] rel_mask;
  logic                timeout;
  logic                entry;

  // Two-flop synchronisers; reset low so sources read as asserted until proven clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_s1_q  <= '0;
      src_s2_q  <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      cal_s1_q  <= 1'b0;
      cal_s2_q  <= 1'b0;
    end else begin
      src_s1_q  <= rst_src_n;
      src_s2_q  <= src_s1_q;
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
      cal_s1_q  <= calibration_done;
      cal_s2_q  <= cal_s1_q;
    end
  end

  assign src_ok  = &src_s2_q;
  assign lock_ok = lock_s2_q;
  assign cal_ok  = cal_s2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    rel_mask   = port_rst_q;
    timeout    = 1'b0;
    entry      = 1'b0;
    pll_rst_d  = 1'b0;
    ddr3_rst_d = 1'b1;
    port_rst_d = '1;
    sys_rst_d  = 1'b1;
    ready_d    = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (src_ok) begin
          if (cnt_q == '0) state_d = S_WAIT_LOCK;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_ok) begin
          if (lock_cnt_q == LOCK_LAST) state_d    = S_DDR_RST;
          else                         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
          lock_cnt_d = '0;
        end
        if (state_d == S_WAIT_LOCK) begin
          if (cnt_q == '0) timeout = 1'b1;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DDR_RST: begin
        if (cnt_q == '0) state_d = S_WAIT_CAL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WAIT_CAL: begin
        if (cal_ok)           state_d = S_RELEASE;
        else if (cnt_q == '0) timeout = 1'b1;
        else                  cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RELEASE: begin
        if (cnt_q == '0) begin
          rel_mask[idx_q] = 1'b0;
          idx_d           = idx_q + IDX_W'(1);
          cnt_d           = STAGGER_LOAD;
          if (idx_q == PORT_LAST) state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN, S_FAULT: ;
      default: state_d = S_PLL_RST;
    endcase

    if (timeout) begin
      retry_d = retry_q + RETRY_W'(1);
      state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_PLL_RST;
    end

    // Run-time losses, applied lowest priority first so the stronger event overrides.
    if (state_q == S_RELEASE || state_q == S_RUN) begin
      if (!cal_ok)  state_d = S_DDR_RST;
      if (!lock_ok) state_d = S_PLL_RST;
    end
    if (!src_ok) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end
    if (state_d == S_RUN) retry_d = '0;

    entry = (state_d != state_q) || !src_ok;
    if (entry) begin
      lock_cnt_d = '0;
      idx_d      = '0;
      rel_mask   = '1;
      case (state_d)
        S_PLL_RST:              cnt_d = PLL_LOAD;
        S_WAIT_LOCK, S_WAIT_CAL: cnt_d = TIMEOUT_LOAD;
        S_DDR_RST:              cnt_d = DDR_LOAD;
        S_RELEASE:              cnt_d = STAGGER_LOAD;
        default:                cnt_d = '0;
      endcase
    end

    // Outputs derive from the next state so they update on the same edge as the FSM.
    pll_rst_d  = (state_d == S_PLL_RST);
    ddr3_rst_d = (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) ||
                 (state_d == S_DDR_RST) || (state_d == S_FAULT);
    case (state_d)
      S_RELEASE: port_rst_d = rel_mask;
      S_RUN:     port_rst_d = '0;
      default:   port_rst_d = '1;
    endcase
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    error_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_PLL_RST;
      cnt_q      <= PLL_LOAD;
      lock_cnt_q <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      ddr3_rst_q <= 1'b1;
      port_rst_q <= '1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      ddr3_rst_q <= ddr3_rst_d;
      port_rst_q <= port_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign ddr3_rst    = ddr3_rst_q;
  assign port_rst    = port_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
